// File: rtl/shift_seq_pkg.sv
// -----------------------------------------------------------------------------
// shift_seq_pkg
// Shared definitions for the sequential shifter and any other datapath block
// (e.g. the ALU) that needs the same shift-op encodings.
//   - DEF_WIDTH / DEF_SHW : default datapath and shift-amount widths
//   - op_t                : shift operation encoding (SLL, SRL, SRA, reserved)
//   - state_t             : one-hot FSM state encoding of shift_seq
// -----------------------------------------------------------------------------
package shift_seq_pkg;

   localparam int DEF_WIDTH = 16;
   localparam int DEF_SHW   = 4;

   typedef enum logic [1:0] {
      OP_SLL = 2'b00,
      OP_SRL = 2'b01,
      OP_SRA = 2'b10,
      OP_RSV = 2'b11
   } op_t;

   // One-hot so that busy/done are a single flop bit each.
   typedef enum logic [2:0] {
      ST_IDLE  = 3'b001,
      ST_SHIFT = 3'b010,
      ST_DONE  = 3'b100
   } state_t;

endpackage : shift_seq_pkg

// File: rtl/shift_seq_if.sv
// -----------------------------------------------------------------------------
// shift_seq_if
// Request/result bundle of the sequential shifter.
//   start  : request pulse, only honoured while the shifter is idle
//   op     : shift operation (see shift_seq_pkg::op_t)
//   A      : operand, captured on an accepted start
//   shamt  : shift amount, captured on an accepted start
//   busy   : high while shifting
//   done   : one-cycle pulse, out is valid
//   out    : result register, held until the next accepted start
// Modports: master = requester, slave = shifter.
// -----------------------------------------------------------------------------
interface shift_seq_if #(
   parameter int WIDTH = shift_seq_pkg::DEF_WIDTH,
   parameter int SHW   = shift_seq_pkg::DEF_SHW
);

   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] A;
   logic [SHW-1:0]   shamt;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] out;

   modport master (
      output start, op, A, shamt,
      input  busy, done, out
   );

   modport slave (
      input  start, op, A, shamt,
      output busy, done, out
   );

endinterface : shift_seq_if

// File: rtl/shift_seq_step.sv
// -----------------------------------------------------------------------------
// shift_step
// Purely combinational single-bit shifter, shared with the ALU.
//   value   : input word
//   op      : OP_SLL (zero into LSB), OP_SRL (zero into MSB),
//             OP_SRA (MSB replicated), OP_RSV (value passes unchanged)
//   shifted : value shifted by one position
// -----------------------------------------------------------------------------
module shift_step
   import shift_seq_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic [WIDTH-1:0] value,
   input  op_t              op,
   output logic [WIDTH-1:0] shifted
);

   // One-position shift selected by op; reserved op is a pass-through.
   always_comb begin
      shifted = value;
      case (op)
         OP_SLL:  shifted = {value[WIDTH-2:0], 1'b0};
         OP_SRL:  shifted = {1'b0, value[WIDTH-1:1]};
         OP_SRA:  shifted = {value[WIDTH-1], value[WIDTH-1:1]};
         OP_RSV:  shifted = value;
         default: shifted = value;
      endcase
   end

endmodule : shift_step

// File: rtl/shift_seq.sv
// -----------------------------------------------------------------------------
// shift_seq
// Multi-cycle shifter: one bit position per clock.
//   clk   : sole clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : shift_seq_if.slave (start/op/A/shamt in, busy/done/out out)
// Timing: accept on edge 0, done is high in cycle shamt+1. shamt==0 or the
// reserved op skip shifting and report done in cycle 1 with out==A.
// start is ignored outside IDLE; a reset abandons any operation without done.
// -----------------------------------------------------------------------------
module shift_seq
   import shift_seq_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int SHW   = DEF_SHW
) (
   input  logic        clk,
   input  logic        rst_n,
   shift_seq_if.slave  bus
);

   localparam logic [SHW-1:0] CNT_ZERO = {SHW{1'b0}};
   localparam logic [SHW-1:0] CNT_ONE  = {{(SHW-1){1'b0}}, 1'b1};

   state_t           state_r;
   state_t           state_nxt;
   logic [SHW-1:0]   cnt_r;
   logic [SHW-1:0]   cnt_nxt;
   logic [WIDTH-1:0] out_r;
   logic [WIDTH-1:0] out_nxt;
   op_t              op_r;
   op_t              op_nxt;
   logic [WIDTH-1:0] step_s;

   shift_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .value   (out_r),
      .op      (op_r),
      .shifted (step_s)
   );

   // Next-state / next-datapath logic; everything holds unless changed.
   always_comb begin
      state_nxt = state_r;
      cnt_nxt   = cnt_r;
      out_nxt   = out_r;
      op_nxt    = op_r;
      case (state_r)
         ST_IDLE: begin
            if (bus.start) begin
               out_nxt = bus.A;
               cnt_nxt = bus.shamt;
               op_nxt  = op_t'(bus.op);
               // Nothing to shift: go straight to DONE so latency is 1.
               if ((bus.shamt != CNT_ZERO) && (op_t'(bus.op) != OP_RSV)) begin
                  state_nxt = ST_SHIFT;
               end else begin
                  state_nxt = ST_DONE;
               end
            end else begin
               state_nxt = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            out_nxt = step_s;
            cnt_nxt = cnt_r - CNT_ONE;
            // cnt==1 means this edge performs the last step.
            if (cnt_r == CNT_ONE) begin
               state_nxt = ST_DONE;
            end else begin
               state_nxt = ST_SHIFT;
            end
         end
         ST_DONE: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            // Illegal encoding: recover to a clean idle state.
            state_nxt = ST_IDLE;
            cnt_nxt   = CNT_ZERO;
            out_nxt   = {WIDTH{1'b0}};
            op_nxt    = OP_SLL;
         end
      endcase
   end

   // State, counter, result and latched-op registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
         cnt_r   <= CNT_ZERO;
         out_r   <= {WIDTH{1'b0}};
         op_r    <= OP_SLL;
      end else begin
         state_r <= state_nxt;
         cnt_r   <= cnt_nxt;
         out_r   <= out_nxt;
         op_r    <= op_nxt;
      end
   end

   // Status flags are straight decodes of the one-hot state register.
   assign bus.busy = (state_r == ST_SHIFT);
   assign bus.done = (state_r == ST_DONE);
   assign bus.out  = out_r;

endmodule : shift_seq

// File: tb/tb_shift_seq.sv
// -----------------------------------------------------------------------------
// tb_shift_seq
// Directed self-checking bench for shift_seq. Inputs change 1 time unit after
// a rising edge, outputs are sampled on the falling edge. Cycle numbering: the
// cycle right after the accepting edge is cycle 1.
// -----------------------------------------------------------------------------
module tb_shift_seq;

   logic clk;
   logic rst_n;
   int   total_cnt;
   int   pass_cnt;

   shift_seq_if #(.WIDTH(16), .SHW(4)) bus ();

   shift_seq #(
      .WIDTH (16),
      .SHW   (4)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Issue one request from idle and observe until done (bounded).
   task automatic run_op(input logic [1:0] op_v, input logic [15:0] a_v,
                         input logic [3:0] sh_v, output int done_cyc,
                         output int busy_cyc, output logic [15:0] res,
                         output logic overlap);
      done_cyc = -1;
      busy_cyc = 0;
      overlap  = 1'b0;
      res      = 16'h0000;
      @(posedge clk); #1;
      bus.start = 1'b1;
      bus.op    = op_v;
      bus.A     = a_v;
      bus.shamt = sh_v;
      @(posedge clk); #1;
      // Scramble inputs after capture; they must not matter.
      bus.start = 1'b0;
      bus.A     = 16'hDEAD;
      bus.shamt = 4'hF;
      bus.op    = 2'b00;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (bus.busy && bus.done) overlap = 1'b1;
         if (bus.busy) busy_cyc++;
         if (bus.done) begin
            done_cyc = c;
            res      = bus.out;
            break;
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      int dc, bc;
      logic [15:0] r;
      logic ov;
      rst_n     = 1'b0;
      bus.start = 1'b1;
      bus.op    = 2'b00;
      bus.A     = 16'h5555;
      bus.shamt = 4'h0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      total_cnt++;
      if (bus.out !== 16'h0000) $display("FAIL reset_out: got %h want 0000", bus.out);
      else pass_cnt++;
      total_cnt++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0)
         $display("FAIL reset_flags: busy=%b done=%b want 0 0", bus.busy, bus.done);
      else pass_cnt++;
      // Release reset with start still high: first edge accepts.
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      @(negedge clk);
      total_cnt++;
      if (bus.done !== 1'b1 || bus.out !== 16'h5555)
         $display("FAIL first_accept: done=%b out=%h want 1 5555", bus.done, bus.out);
      else pass_cnt++;
      @(posedge clk); #1;
      run_op(2'b10, 16'h0002, 4'd1, dc, bc, r, ov);
      total_cnt++;
      if (dc !== 2 || r !== 16'h0001)
         $display("FAIL sra1: done_cycle=%0d out=%h want 2 0001", dc, r);
      else pass_cnt++;
   endtask

   task automatic test_sra();
      int dc, bc;
      logic [15:0] r;
      logic ov;
      run_op(2'b10, 16'h8000, 4'd4, dc, bc, r, ov);
      total_cnt++;
      if (dc !== 5 || r !== 16'hF800)
         $display("FAIL sra4: done_cycle=%0d out=%h want 5 F800", dc, r);
      else pass_cnt++;
      total_cnt++;
      if (bc !== 4 || ov !== 1'b0)
         $display("FAIL sra4_busy: busy_cycles=%0d overlap=%b want 4 0", bc, ov);
      else pass_cnt++;
      run_op(2'b10, 16'h7FF0, 4'd4, dc, bc, r, ov);
      total_cnt++;
      if (dc !== 5 || r !== 16'h07FF)
         $display("FAIL sra4_pos: done_cycle=%0d out=%h want 5 07FF", dc, r);
      else pass_cnt++;
   endtask

   task automatic test_long();
      int dc, bc;
      logic [15:0] r;
      logic ov;
      run_op(2'b01, 16'h8001, 4'd15, dc, bc, r, ov);
      total_cnt++;
      if (dc !== 16 || r !== 16'h0001 || bc !== 15)
         $display("FAIL srl15: done_cycle=%0d out=%h busy=%0d want 16 0001 15", dc, r, bc);
      else pass_cnt++;
      run_op(2'b00, 16'h0001, 4'd15, dc, bc, r, ov);
      total_cnt++;
      if (dc !== 16 || r !== 16'h8000)
         $display("FAIL sll15: done_cycle=%0d out=%h want 16 8000", dc, r);
      else pass_cnt++;
   endtask

   task automatic test_no_shift();
      int dc, bc;
      logic [15:0] r;
      logic ov;
      run_op(2'b01, 16'h1234, 4'd0, dc, bc, r, ov);
      total_cnt++;
      if (dc !== 1 || r !== 16'h1234 || bc !== 0)
         $display("FAIL shamt0: done_cycle=%0d out=%h busy=%0d want 1 1234 0", dc, r, bc);
      else pass_cnt++;
      run_op(2'b11, 16'h1234, 4'd5, dc, bc, r, ov);
      total_cnt++;
      if (dc !== 1 || r !== 16'h1234 || bc !== 0)
         $display("FAIL op_rsv: done_cycle=%0d out=%h busy=%0d want 1 1234 0", dc, r, bc);
      else pass_cnt++;
   endtask

   task automatic test_ignore_start();
      int dc;
      dc = -1;
      @(posedge clk); #1;
      bus.start = 1'b1;
      bus.op    = 2'b10;
      bus.A     = 16'h8000;
      bus.shamt = 4'd4;
      @(posedge clk); #1;          // accepting edge, now cycle 1
      bus.start = 1'b0;
      @(posedge clk); #1;          // cycle 2: raise a second start
      bus.start = 1'b1;
      bus.op    = 2'b00;
      bus.A     = 16'hFFFF;
      bus.shamt = 4'd1;
      @(negedge clk);
      total_cnt++;
      if (bus.busy !== 1'b1) $display("FAIL ign_busy: busy=%b want 1", bus.busy);
      else pass_cnt++;
      @(posedge clk); #1;
      bus.start = 1'b0;
      for (int c = 3; c <= 20; c++) begin
         @(negedge clk);
         if (bus.done) begin
            dc = c;
            break;
         end
         @(posedge clk); #1;
      end
      total_cnt++;
      if (dc !== 5 || bus.out !== 16'hF800)
         $display("FAIL ign_start: done_cycle=%0d out=%h want 5 F800", dc, bus.out);
      else pass_cnt++;
      // Result must hold in the following idle cycles.
      repeat (2) @(posedge clk);
      @(negedge clk);
      total_cnt++;
      if (bus.out !== 16'hF800 || bus.done !== 1'b0 || bus.busy !== 1'b0)
         $display("FAIL idle_hold: out=%h done=%b busy=%b want F800 0 0",
                  bus.out, bus.done, bus.busy);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      int dc, bc, seen_done;
      logic [15:0] r;
      logic ov;
      seen_done = 0;
      @(posedge clk); #1;
      bus.start = 1'b1;
      bus.op    = 2'b01;
      bus.A     = 16'hFF00;
      bus.shamt = 4'd8;
      @(posedge clk); #1;          // cycle 1
      bus.start = 1'b0;
      @(posedge clk); #1;          // cycle 2
      @(posedge clk); #1;          // cycle 3
      rst_n = 1'b0;
      @(negedge clk);
      total_cnt++;
      if (bus.busy !== 1'b1) $display("FAIL mid_busy: busy=%b want 1", bus.busy);
      else pass_cnt++;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      total_cnt++;
      if (bus.out !== 16'h0000 || bus.busy !== 1'b0 || bus.done !== 1'b0)
         $display("FAIL mid_reset: out=%h busy=%b done=%b want 0000 0 0",
                  bus.out, bus.busy, bus.done);
      else pass_cnt++;
      repeat (10) begin
         @(negedge clk);
         if (bus.done) seen_done++;
      end
      total_cnt++;
      if (seen_done !== 0) $display("FAIL abandoned_done: pulses=%0d want 0", seen_done);
      else pass_cnt++;
      run_op(2'b00, 16'h0003, 4'd2, dc, bc, r, ov);
      total_cnt++;
      if (dc !== 3 || r !== 16'h000C)
         $display("FAIL after_reset: done_cycle=%0d out=%h want 3 000C", dc, r);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      int dc, bc;
      logic [15:0] r;
      logic ov;
      run_op(2'b01, 16'hA5A5, 4'd3, dc, bc, r, ov);
      total_cnt++;
      if (dc !== 4 || r !== 16'h14B4)
         $display("FAIL b2b_1: done_cycle=%0d out=%h want 4 14B4", dc, r);
      else pass_cnt++;
      run_op(2'b00, 16'hA5A5, 4'd4, dc, bc, r, ov);
      total_cnt++;
      if (dc !== 5 || r !== 16'h5A50)
         $display("FAIL b2b_2: done_cycle=%0d out=%h want 5 5A50", dc, r);
      else pass_cnt++;
   endtask

   initial begin
      total_cnt = 0;
      pass_cnt  = 0;
      rst_n     = 1'b0;
      bus.start = 1'b0;
      bus.op    = 2'b00;
      bus.A     = 16'h0000;
      bus.shamt = 4'h0;
      test_reset();
      test_sra();
      test_long();
      test_no_shift();
      test_ignore_start();
      test_reset_mid();
      test_back_to_back();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule : tb_shift_seq
